// File: rtl/spi_slave_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave_shift                                                 |
// | Purpose  : SPI target shift engine. Oversamples SCLK/SS_N/MOSI in the      |
// |            wb_clk_in domain, deserialises MOSI into rx_data and serialises |
// |            a single-entry TX buffer onto MISO. All CPOL/CPHA modes,        |
// |            MSB/LSB first, programmable character length.                   |
// | Options  : SPI_SLV_UNDERRUN_EN - enables the sticky tx_underrun flag.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_slave_shift #(
  parameter int CHAR_LEN = 32,
  parameter int LEN_BITS = 5
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst,
  input  logic                sclk_pad,
  input  logic                ss_n_pad,
  input  logic                mosi_pad,
  output logic                miso,
  output logic                miso_oe,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb,
  input  logic [LEN_BITS-1:0] len,
  input  logic [CHAR_LEN-1:0] tx_data,
  input  logic                tx_load,
  output logic                tx_ready,
  output logic [CHAR_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                tx_underrun
);

  localparam logic [LEN_BITS:0] c_char_len = (LEN_BITS+1)'(CHAR_LEN);
  localparam logic [LEN_BITS:0] c_one      = (LEN_BITS+1)'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t r_state, w_state_next;
  logic   w_start, w_stop;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_ss_s1, r_ss_s2;
  logic r_mosi_s1, r_mosi_s2;

  logic                r_cpol, r_cpha, r_lsb;
  logic [LEN_BITS:0]   r_n;
  logic [LEN_BITS-1:0] r_bit_cnt;
  logic [CHAR_LEN-1:0] r_tx_shift, r_rx_shift, r_tx_buf;
  logic                r_tx_ready, r_rx_done;
  logic                r_miso, r_miso_oe, r_rx_valid;
  logic [CHAR_LEN-1:0] r_rx_data;

  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
  logic w_active_run, w_last, w_char_end, w_consume, w_load_ok;
  logic [LEN_BITS:0]   w_n_in;
  logic [LEN_BITS-1:0] w_pos, w_pos0, w_pos0_in;
  logic [CHAR_LEN-1:0] w_tx_next, w_rx_next;

  // Bit position on the wire for a given bit count, MSB-first or LSB-first.
  function automatic logic [LEN_BITS-1:0] f_pos(input logic l,
                                                input logic [LEN_BITS:0] n,
                                                input logic [LEN_BITS-1:0] cnt);
    logic [LEN_BITS:0] t;
    t = n - {1'b0, cnt} - c_one;
    return l ? cnt : t[LEN_BITS-1:0];
  endfunction

  // Two-flop synchronisers on every pad plus a delayed SCLK copy for edge detect.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk_pad;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ss_s1   <= ss_n_pad;
      r_ss_s2   <= r_ss_s1;
      r_mosi_s1 <= mosi_pad;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Edge classification uses the configuration latched at selection.
  assign w_rise   = r_sclk_s2 & ~r_sclk_d;
  assign w_fall   = ~r_sclk_s2 & r_sclk_d;
  assign w_lead   = r_cpol ? w_fall : w_rise;
  assign w_trail  = r_cpol ? w_rise : w_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead : w_trail;

  assign w_n_in       = (len == '0) ? c_char_len : {1'b0, len};
  assign w_pos        = f_pos(r_lsb, r_n, r_bit_cnt);
  assign w_pos0       = f_pos(r_lsb, r_n, '0);
  assign w_pos0_in    = f_pos(lsb, w_n_in, '0);
  assign w_last       = ({1'b0, r_bit_cnt} == (r_n - c_one));
  assign w_active_run = (r_state == S_ACTIVE) & ~r_ss_s2;
  assign w_char_end   = w_active_run & w_sample & w_last;
  // An empty buffer at character start sends zeros.
  assign w_tx_next    = r_tx_ready ? '0 : r_tx_buf;
  assign w_consume    = w_start | w_char_end;
  assign w_load_ok    = tx_load & r_tx_ready & ~w_consume;

  // Receive word with the current MOSI bit merged in at its position.
  always_comb begin
    w_rx_next        = r_rx_shift;
    w_rx_next[w_pos] = r_mosi_s2;
  end

  // FSM state register.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state: select starts a frame, deselect ends it.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_ss_s2) begin
          w_start      = 1'b1;
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (r_ss_s2) begin
          w_stop       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shift datapath: config latch, MISO drive, MOSI capture and RX hand-off.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_n        <= c_char_len;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      // Completed character is published one cycle after its last sample.
      if (r_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        r_rx_done  <= 1'b0;
        r_rx_shift <= '0;
      end
      if (w_start) begin
        r_cpol     <= cpol;
        r_cpha     <= cpha;
        r_lsb      <= lsb;
        r_n        <= w_n_in;
        r_bit_cnt  <= '0;
        r_miso_oe  <= 1'b1;
        r_tx_shift <= w_tx_next;
        r_rx_shift <= '0;
        r_miso     <= cpha ? 1'b0 : w_tx_next[w_pos0_in];
      end else if (w_stop) begin
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
      end else if (w_active_run) begin
        if (w_shift) r_miso <= r_tx_shift[w_pos];
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          if (w_last) begin
            r_bit_cnt  <= '0;
            r_rx_done  <= 1'b1;
            r_tx_shift <= w_tx_next;
            if (!r_cpha) r_miso <= w_tx_next[w_pos0];
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Single-entry TX buffer; a consume in the same cycle drops a load.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
    end else if (w_consume) begin
      r_tx_ready <= 1'b1;
    end else if (w_load_ok) begin
      r_tx_buf   <= tx_data;
      r_tx_ready <= 1'b0;
    end
  end

`ifdef SPI_SLV_UNDERRUN_EN
  logic r_tx_underrun;

  // Sticky underrun: set when a character starts empty, cleared by a load.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst)                      r_tx_underrun <= 1'b0;
    else if (w_consume & r_tx_ready) r_tx_underrun <= 1'b1;
    else if (w_load_ok)              r_tx_underrun <= 1'b0;
  end

  assign tx_underrun = r_tx_underrun;
`else
  assign tx_underrun = 1'b0;
`endif

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state == S_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_slave_shift                                              |
// | Purpose  : Self-checking bench for spi_slave_shift: a timed SPI master     |
// |            model drives the pads, received words go through a scoreboard. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_spi_slave_shift;

  logic        wb_clk_in = 1'b0;
  logic        wb_rst;
  logic        sclk_pad, ss_n_pad, mosi_pad;
  logic        miso, miso_oe;
  logic        cpol, cpha, lsb;
  logic [4:0]  len;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        tx_underrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rx_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mw[0:1];
  logic [31:0] sw[0:1];
  logic        exp_urun;

  spi_slave_shift #(.CHAR_LEN(32), .LEN_BITS(5)) u_dut (
    .wb_clk_in   (wb_clk_in),
    .wb_rst      (wb_rst),
    .sclk_pad    (sclk_pad),
    .ss_n_pad    (ss_n_pad),
    .mosi_pad    (mosi_pad),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb         (lsb),
    .len         (len),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  always #5 wb_clk_in = ~wb_clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Received words are compared against the scoreboard as they appear.
  always @(negedge wb_clk_in) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("rx_unexpected", 32'(exp_q.size()), 32'd1);
      else                   check("rx_data", rx_data, exp_q.pop_front());
    end
  end

  task automatic half_period();
    repeat (8) @(negedge wb_clk_in);
  endtask

  task automatic load_tx(input logic [31:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge wb_clk_in);
    tx_load = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
  endtask

  // Master frame: words from mw[], expected MISO words in sw[].
  // stop_bits >= 0 deselects early after that many bits; do_rst pulses reset then.
  task automatic spi_frame(input logic f_cpol, input logic f_cpha, input logic f_lsb,
                           input logic [4:0] f_len, input int nwords, input int stop_bits,
                           input bit do_rst, input bit do_reload, input logic [31:0] reload_val);
    int          n, p, bits, rx0;
    bit          aborted, stop;
    logic [31:0] got, mask;
    n       = (f_len == 0) ? 32 : int'(f_len);
    mask    = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    aborted = (stop_bits >= 0);
    stop    = 1'b0;
    bits    = 0;
    cpol = f_cpol; cpha = f_cpha; lsb = f_lsb; len = f_len;
    sclk_pad = f_cpol;
    mosi_pad = 1'b0;
    repeat (6) @(negedge wb_clk_in);
    rx0 = rx_cnt;
    if (!aborted) for (int w = 0; w < nwords; w++) exp_q.push_back(mw[w] & mask);
    ss_n_pad = 1'b0;
    for (int w = 0; w < nwords && !stop; w++) begin
      got = '0;
      for (int b = 0; b < n && !stop; b++) begin
        p = f_lsb ? b : n - 1 - b;
        if (!f_cpha) begin
          mosi_pad = mw[w][p];
          half_period();
          sclk_pad = ~f_cpol;
          got[p]   = miso;
          half_period();
          sclk_pad = f_cpol;
        end else begin
          half_period();
          sclk_pad = ~f_cpol;
          mosi_pad = mw[w][p];
          half_period();
          sclk_pad = f_cpol;
          got[p]   = miso;
        end
        if (w == 0 && b == 0) begin
          check("busy_sel", {31'd0, busy}, 32'd1);
          check("miso_oe_sel", {31'd0, miso_oe}, 32'd1);
          if (do_reload) begin
            check("tx_ready_consumed", {31'd0, tx_ready}, 32'd1);
            load_tx(reload_val);
          end
        end
        bits++;
        if (aborted && bits == stop_bits) stop = 1'b1;
      end
      if (!aborted) check($sformatf("miso_word%0d", w), got, sw[w] & mask);
    end
    half_period();
    if (do_rst) begin
      wb_rst = 1'b1;
      @(negedge wb_clk_in);
      check_reset_outputs();
      ss_n_pad = 1'b1;
      repeat (3) @(negedge wb_clk_in);
      wb_rst = 1'b0;
    end else begin
      ss_n_pad = 1'b1;
    end
    repeat (8) @(negedge wb_clk_in);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("miso_oe_end", {31'd0, miso_oe}, 32'd0);
    check("miso_end", {31'd0, miso}, 32'd0);
    check("rx_count", 32'(rx_cnt - rx0), aborted ? 32'd0 : 32'(nwords));
  endtask

  initial begin
`ifdef SPI_SLV_UNDERRUN_EN
    exp_urun = 1'b1;
`else
    exp_urun = 1'b0;
`endif
    wb_rst = 1'b1;
    sclk_pad = 1'b0; ss_n_pad = 1'b1; mosi_pad = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; len = 5'd8;
    tx_data = '0; tx_load = 1'b0;
    repeat (3) @(negedge wb_clk_in);
    wb_rst = 1'b0;
    @(negedge wb_clk_in);
    check_reset_outputs();

    // Mode 0, MSB first, 8 bits.
    load_tx(32'h0000_00A5);
    check("tx_ready_loaded", {31'd0, tx_ready}, 32'd0);
    mw[0] = 32'h0000_003C; sw[0] = 32'h0000_00A5;
    spi_frame(1'b0, 1'b0, 1'b0, 5'd8, 1, -1, 1'b0, 1'b0, 32'd0);
    check("tx_ready_after", {31'd0, tx_ready}, 32'd1);

    // Mode 3, LSB first, 8 bits; an accepted load clears any underrun.
    load_tx(32'h0000_0081);
    check("urun_cleared_t2", {31'd0, tx_underrun}, 32'd0);
    mw[0] = 32'h0000_000F; sw[0] = 32'h0000_0081;
    spi_frame(1'b1, 1'b1, 1'b0 | 1'b1, 5'd8, 1, -1, 1'b0, 1'b0, 32'd0);

    // Mode 1, full 32-bit characters, two back-to-back words in one select.
    load_tx(32'hDEAD_BEEF);
    mw[0] = 32'hCAFE_F00D; sw[0] = 32'hDEAD_BEEF;
    mw[1] = 32'h0BAD_C0DE; sw[1] = 32'h1234_5678;
    spi_frame(1'b0, 1'b1, 1'b0, 5'd0, 2, -1, 1'b0, 1'b1, 32'h1234_5678);

    // Deselect after 5 bits: partial character discarded.
    load_tx(32'h0000_003C);
    mw[0] = 32'h0000_00FF; sw[0] = 32'h0000_003C;
    spi_frame(1'b0, 1'b0, 1'b0, 5'd8, 1, 5, 1'b0, 1'b0, 32'd0);
    check("rx_data_kept", rx_data, 32'h0BAD_C0DE);

    // Next frame with no TX load: MISO all zero, underrun per build.
    mw[0] = 32'h0000_0055; sw[0] = 32'h0000_0000;
    spi_frame(1'b0, 1'b0, 1'b0, 5'd8, 1, -1, 1'b0, 1'b0, 32'd0);
    check("rx_data_55", rx_data, 32'h0000_0055);
    check("urun_set", {31'd0, tx_underrun}, {31'd0, exp_urun});
    load_tx(32'h0000_0011);
    check("urun_cleared", {31'd0, tx_underrun}, 32'd0);
    check("tx_ready_t5", {31'd0, tx_ready}, 32'd0);

    // Reset after 3 bits, then a clean frame.
    mw[0] = 32'h0000_00AA; sw[0] = 32'h0;
    spi_frame(1'b0, 1'b0, 1'b0, 5'd8, 1, 3, 1'b1, 1'b0, 32'd0);
    load_tx(32'h0000_0066);
    mw[0] = 32'h0000_0099; sw[0] = 32'h0000_0066;
    spi_frame(1'b0, 1'b0, 1'b0, 5'd8, 1, -1, 1'b0, 1'b0, 32'd0);
    check("rx_data_99", rx_data, 32'h0000_0099);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
